substitution_layer_iter: RTL and testbench

Parametrised, iterative successor to the combinational Ascon substitution layer. It applies the 5-bit Ascon S-box to all 64 bit-columns of a `type_state` (5 × 64-bit words from `ascon_pack`). It processes `SLICES` columns per clock, which trades area for latency. It sits between the constant-addition and linear-diffusion stages of a round datapath, using valid/ready handshakes on both sides.

---
 rtl/substitution_layer_iter.sv | 163 ++++++++++++++++
 tb/tb_substitution_layer_iter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/substitution_layer_iter.sv
// Iterative Ascon substitution layer: SLICES columns per cycle over NCYC cycles.
// Optional inverse S-box bank enabled by defining SUB_LAYER_INV_EN.
package ascon_pack;
  typedef logic [4:0][63:0] type_state;
endpackage

module substitution_layer_iter
  import ascon_pack::*;
#(
  parameter int SLICES = 8
) (
  input  logic      clock_i,
  input  logic      resetb_i,
  input  logic      in_valid_i,
  output logic      in_ready_o,
  input  type_state state_i,
  output logic      out_valid_o,
  input  logic      out_ready_i,
  output type_state state_o
`ifdef SUB_LAYER_INV_EN
  ,
  input  logic      inv_i
`endif
);

  localparam int NCYC = (SLICES > 0) ? 64 / SLICES : 1;
  localparam int CW = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (!(SLICES == 1 || SLICES == 2 || SLICES == 4 ||
        SLICES == 8 || SLICES == 16 || SLICES == 32 ||
        SLICES == 64)) begin : g_bad_slices
    $error("SLICES must be a power of two in 1..64");
  end

  localparam logic [4:0] FWD [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

`ifdef SUB_LAYER_INV_EN
  localparam logic [4:0] INV [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };
  logic inv_q;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t      st;
  fsm_t      st_nx;
  type_state work;
  logic      last;
  logic      acc;
  logic [5:0] base;

  logic [4:0][SLICES-1:0] sl;
  logic [4:0][SLICES-1:0] nsl;
  logic [SLICES-1:0][4:0] col;
  logic [SLICES-1:0][4:0] sub;

  assign acc = in_valid_i & in_ready_o;

  if (NCYC > 1) begin : g_cnt
    logic [CW-1:0] cnt;

    // Power-of-two NCYC lets the counter wrap to 0 on its own.
    always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
        cnt <= '0;
      end else if (acc) begin
        cnt <= '0;
      end else if (st == RUN) begin
        cnt <= cnt + CW'(1);
      end
    end

    assign last = (cnt == CW'(NCYC - 1));
    assign base = 6'(int'(cnt) * SLICES);
  end else begin : g_nocnt
    assign last = 1'b1;
    assign base = 6'd0;
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      st <= IDLE;
    end else begin
      st <= st_nx;
    end
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: if (in_valid_i) st_nx = RUN;
      RUN:  if (last) st_nx = DONE;
      DONE: begin
        if (out_ready_i) begin
          st_nx = in_valid_i ? RUN : IDLE;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (st == IDLE) | ((st == DONE) & out_ready_i);
    out_valid_o = (st == DONE);
  end

  always_comb begin
    sl  = '0;
    nsl = '0;
    col = '0;
    sub = '0;
    for (int w = 0; w < 5; w++) begin
      sl[w] = work[w][base +: SLICES];
    end
    for (int s = 0; s < SLICES; s++) begin
      col[s] = {sl[0][s], sl[1][s], sl[2][s], sl[3][s], sl[4][s]};
`ifdef SUB_LAYER_INV_EN
      sub[s] = inv_q ? INV[col[s]] : FWD[col[s]];
`else
      sub[s] = FWD[col[s]];
`endif
      nsl[0][s] = sub[s][4];
      nsl[1][s] = sub[s][3];
      nsl[2][s] = sub[s][2];
      nsl[3][s] = sub[s][1];
      nsl[4][s] = sub[s][0];
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      work <= '0;
    end else if (acc) begin
      work <= state_i;
    end else if (st == RUN) begin
      for (int w = 0; w < 5; w++) begin
        work[w][base +: SLICES] <= nsl[w];
      end
    end
  end

`ifdef SUB_LAYER_INV_EN
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      inv_q <= 1'b0;
    end else if (acc) begin
      inv_q <= inv_i;
    end
  end
`endif

  assign state_o = work;

endmodule

// File: tb/tb_substitution_layer_iter.sv
// Bench for substitution_layer_iter: column-wise S-box model plus
// directed vectors on SLICES = 8, 64 and 1 instances.
module tb_substitution_layer_iter;
  import ascon_pack::*;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int NC [3] = '{8, 1, 64};

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] iv;
  logic [2:0] rdy;
  logic [2:0] ov;
  logic [2:0] ordy;
  type_state  st_in;
  type_state  so [3];
  logic       inv;

  int tests = 0;
  int fails = 0;

  logic [4:0] isbox [32];

  substitution_layer_iter #(.SLICES(8)) dut8 (
    .clock_i(clk), .resetb_i(rst_n),
    .in_valid_i(iv[0]), .in_ready_o(rdy[0]), .state_i(st_in),
    .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .state_o(so[0])
`ifdef SUB_LAYER_INV_EN
    , .inv_i(inv)
`endif
  );

  substitution_layer_iter #(.SLICES(64)) dut64 (
    .clock_i(clk), .resetb_i(rst_n),
    .in_valid_i(iv[1]), .in_ready_o(rdy[1]), .state_i(st_in),
    .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .state_o(so[1])
`ifdef SUB_LAYER_INV_EN
    , .inv_i(inv)
`endif
  );

  substitution_layer_iter #(.SLICES(1)) dut1 (
    .clock_i(clk), .resetb_i(rst_n),
    .in_valid_i(iv[2]), .in_ready_o(rdy[2]), .state_i(st_in),
    .out_valid_o(ov[2]), .out_ready_i(ordy[2]), .state_o(so[2])
`ifdef SUB_LAYER_INV_EN
    , .inv_i(inv)
`endif
  );

  initial begin
    for (int i = 0; i < 32; i++) isbox[SBOX[i]] = 5'(i);
  end

  function automatic type_state mk(logic [63:0] a, logic [63:0] b,
                                   logic [63:0] c, logic [63:0] d,
                                   logic [63:0] e);
    type_state r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
    return r;
  endfunction

  // Column j = {x0[j],..,x4[j]}, substituted through a table lookup.
  function automatic type_state sbox_state(type_state s, logic iflag);
    type_state r;
    logic [4:0] c;
    logic [4:0] o;
    for (int j = 0; j < 64; j++) begin
      c = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
      o = iflag ? isbox[c] : SBOX[c];
      for (int w = 0; w < 5; w++) r[w][j] = o[4-w];
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [319:0] act, logic [319:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level timing model: result due NCYC edges after acceptance.
  int        m_busy  [3];
  logic      m_valid [3];
  type_state m_pend  [3];
  type_state m_out   [3];

  function automatic logic exp_rdy(int i);
    return (m_busy[i] == 0) && (!m_valid[i] || ordy[i]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i]  <= 0;
        m_valid[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_busy[i] == 1) begin
          m_valid[i] <= 1'b1;
          m_out[i]   <= m_pend[i];
        end else if (m_valid[i] && ordy[i]) begin
          m_valid[i] <= 1'b0;
        end
        if (m_busy[i] > 0) m_busy[i] <= m_busy[i] - 1;
        if (iv[i] && exp_rdy(i)) begin
          m_pend[i] <= sbox_state(st_in, inv);
          m_busy[i] <= NC[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("cyc_ready%0d", i), rdy[i], exp_rdy(i));
        chk($sformatf("cyc_valid%0d", i), ov[i], m_valid[i]);
        if (m_valid[i]) chk($sformatf("cyc_state%0d", i), so[i], m_out[i]);
      end
    end
  end

  task automatic send(int i, type_state s, logic iflag);
    logic ok;
    ok = 1'b0;
    st_in = s;
    inv = iflag;
    iv[i] = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (rdy[i]) begin
        @(posedge clk); #2;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    iv[i] = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_out(int i, output int lat);
    lat = -1;
    for (int n = 1; n < 300; n++) begin
      @(negedge clk);
      if (ov[i]) begin
        lat = n - 1;
        break;
      end
    end
    if (lat < 0) chk("wait_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  type_state sa, sb, sc, y, r;
  int lat;

  initial begin
    iv = '0;
    ordy = '1;
    inv = 1'b0;
    st_in = '0;

    chk("model_zero", sbox_state('0, 1'b0), mk(0, 0, ONES, 0, 0));
    chk("model_ones", sbox_state(mk(ONES, ONES, ONES, ONES, ONES), 1'b0),
        mk(ONES, 0, ONES, ONES, ONES));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rdy[0], 1);
    chk("rst_valid", ov[0], 0);
    chk("rst_state", so[0], '0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    send(0, '0, 1'b0);
    wait_out(0, lat);
    chk("zero_lat8", lat, 8);
    chk("zero_res", so[0], mk(0, 0, ONES, 0, 0));
    @(posedge clk); #2;

    send(0, mk(ONES, ONES, ONES, ONES, ONES), 1'b0);
    wait_out(0, lat);
    chk("ones_lat8", lat, 8);
    chk("ones_res", so[0], mk(ONES, 0, ONES, ONES, ONES));
    @(posedge clk); #2;

    send(0, mk(64'h1, 0, 0, 0, 0), 1'b0);
    wait_out(0, lat);
    chk("x0bit_res", so[0], mk(64'h1, 64'h1, ONES, 64'h1, 0));
    @(posedge clk); #2;

    send(1, mk(ONES, ONES, ONES, ONES, ONES), 1'b0);
    wait_out(1, lat);
    chk("s64_lat1", lat, 1);
    chk("s64_res", so[1], mk(ONES, 0, ONES, ONES, ONES));
    @(posedge clk); #2;

    send(2, mk(ONES, ONES, ONES, ONES, ONES), 1'b0);
    wait_out(2, lat);
    chk("s1_lat64", lat, 64);
    chk("s1_res", so[2], mk(ONES, 0, ONES, ONES, ONES));
    @(posedge clk); #2;

    sa = mk(64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
            64'h0f0f_0f0f_f0f0_f0f0, 64'haaaa_5555_aaaa_5555,
            64'h1357_9bdf_0246_8ace);
    sb = mk(64'hdead_beef_cafe_f00d, 64'h0, ONES,
            64'h8000_0000_0000_0001, 64'h3c3c_3c3c_c3c3_c3c3);
    sc = mk(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
            64'h9999_aaaa_bbbb_cccc, 64'hdddd_eeee_ffff_0000,
            64'h0000_ffff_0000_ffff);
    send(0, sa, 1'b0);
    st_in = sb;
    iv[0] = 1'b1;
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rdy[0]) begin
        lat = n;
        chk("b2b_accept_in_done", ov[0], 1);
        chk("b2b_first_res", so[0], sbox_state(sa, 1'b0));
        break;
      end
    end
    if (lat < 0) chk("b2b_accept_timeout", 0, 1);
    @(posedge clk); #2;
    iv[0] = 1'b0;
    ordy[0] = 1'b0;
    st_in = sc;
    iv[0] = 1'b1;
    @(negedge clk);
    chk("run_no_accept", rdy[0], 0);
    wait_out(0, lat);
    chk("b2b_lat", lat, 7);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", ov[0], 1);
      chk("hold_state", so[0], sbox_state(sb, 1'b0));
      chk("hold_no_accept", rdy[0], 0);
      @(posedge clk); #2;
      if (k < 4) @(negedge clk);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("c_accept", rdy[0], 1);
    @(posedge clk); #2;
    iv[0] = 1'b0;
    wait_out(0, lat);
    chk("c_lat", lat, 8);
    chk("c_res", so[0], sbox_state(sc, 1'b0));
    @(posedge clk); #2;

    send(0, mk(ONES, ONES, ONES, ONES, ONES), 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_rst_ready", rdy[0], 1);
    chk("midrun_rst_valid", ov[0], 0);
    chk("midrun_rst_state", so[0], '0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      chk("no_partial_out", ov[0], 0);
    end
    @(posedge clk); #2;

`ifdef SUB_LAYER_INV_EN
    send(0, '0, 1'b1);
    wait_out(0, lat);
    chk("inv_zero_res", so[0], mk(ONES, 0, ONES, 0, 0));
    @(posedge clk); #2;

    r = mk({$urandom, $urandom}, {$urandom, $urandom},
           {$urandom, $urandom}, {$urandom, $urandom},
           {$urandom, $urandom});
    send(0, r, 1'b0);
    wait_out(0, lat);
    y = so[0];
    @(posedge clk); #2;
    send(0, y, 1'b1);
    wait_out(0, lat);
    chk("inv_roundtrip", so[0], r);
    @(posedge clk); #2;
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
